// File: rtl/fwd_tracker.sv
// ---------------------------------------------------------------------------
// fwd_tracker
//
// Keeps a short history of the instructions that have left the execute
// stage (entry 0 = MEM, entry STAGES-1 = WB). From that history it works out
// which pipeline stage each EX source operand has to be bypassed from. It
// also flags load-use hazards that force EX to hold, and counts how many
// cycles those hazards cost.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   stall_i         pipeline freeze; all tracker state holds
//   flush_i         squash the instruction currently in EX
//   ex_valid        EX slot holds a real instruction
//   ex_rd           EX destination register
//   ex_wr           EX instruction writes ex_rd
//   ex_load         EX instruction is a load
//   ex_rs           EX source registers, source i in [i*RW +: RW]
//   dec_rs          decode-stage source registers, same packing
//   fwd_sel         one-hot per source, bit i*STAGES+k selects stage k
//   dec_fwd         decode source i reads the write-back result
//   load_use_stall  EX must hold because a source waits on a load in MEM
//   lu_count        saturating count of cycles spent in load-use stall
// ---------------------------------------------------------------------------
module fwd_tracker #(
  parameter int STAGES  = 2,
  parameter int NUM_SRC = 2,
  parameter int RW      = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      ex_valid,
  input  logic [RW-1:0]             ex_rd,
  input  logic                      ex_wr,
  input  logic                      ex_load,
  input  logic [NUM_SRC*RW-1:0]     ex_rs,
  input  logic [NUM_SRC*RW-1:0]     dec_rs,
  output logic [NUM_SRC*STAGES-1:0] fwd_sel,
  output logic [NUM_SRC-1:0]        dec_fwd,
  output logic                      load_use_stall,
  output logic [31:0]               lu_count
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] wr_q, wr_d;
  logic [STAGES-1:0] load_q, load_d;
  logic [RW-1:0]     rd_q [STAGES];
  logic [RW-1:0]     rd_d [STAGES];
  logic [31:0]       lu_count_q, lu_count_d;

  logic [STAGES-1:0] live;
  logic              lu_hit;

  // An entry can only supply a value if it really writes a non-zero register.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      live[k] = valid_q[k] & wr_q[k] & (rd_q[k] != '0);
    end
  end

  // Per-source priority search, youngest entry first. A hit on a load still
  // sitting in MEM consumes the match (an older copy must not be used) but
  // produces no select, because the loaded data does not exist yet.
  always_comb begin
    logic          matched;
    logic [RW-1:0] src;
    fwd_sel = '0;
    lu_hit  = 1'b0;
    matched = 1'b0;
    src     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      matched = 1'b0;
      src     = ex_rs[i*RW +: RW];
      for (int k = 0; k < STAGES; k++) begin
        if (!matched && live[k] && (rd_q[k] == src) && (src != '0)) begin
          matched = 1'b1;
          if (k == 0 && load_q[0]) begin
            lu_hit = 1'b1;
          end else begin
            fwd_sel[i*STAGES + k] = 1'b1;
          end
        end
      end
    end
  end

  // Only a real, unsquashed consumer in EX actually has to wait for the load.
  assign load_use_stall = lu_hit & ex_valid & ~flush_i;

  // The decode bypass only looks at the write-back entry; younger producers
  // are caught later by the EX forwarding network.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      dec_fwd[i] = live[STAGES-1]
                   && (rd_q[STAGES-1] == dec_rs[i*RW +: RW])
                   && (dec_rs[i*RW +: RW] != '0);
    end
  end

  // History shift. Entry 0 receives a bubble when EX is empty, squashed, or
  // held back by a load-use hazard, since in that case the EX instruction
  // has not really advanced.
  always_comb begin
    valid_d    = valid_q;
    wr_d       = wr_q;
    load_d     = load_q;
    rd_d       = rd_q;
    lu_count_d = lu_count_q;
    if (!stall_i) begin
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        wr_d[k]    = wr_q[k-1];
        load_d[k]  = load_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      valid_d[0] = ex_valid & ~flush_i & ~load_use_stall;
      wr_d[0]    = ex_wr;
      load_d[0]  = ex_load;
      rd_d[0]    = ex_rd;
      if (load_use_stall && (lu_count_q != 32'hFFFF_FFFF)) begin
        lu_count_d = lu_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      wr_q       <= '0;
      load_q     <= '0;
      for (int k = 0; k < STAGES; k++) begin
        rd_q[k] <= '0;
      end
      lu_count_q <= '0;
    end else begin
      valid_q    <= valid_d;
      wr_q       <= wr_d;
      load_q     <= load_d;
      rd_q       <= rd_d;
      lu_count_q <= lu_count_d;
    end
  end

  assign lu_count = lu_count_q;

endmodule

// File: tb/tb_fwd_tracker.sv
// ---------------------------------------------------------------------------
// tb_fwd_tracker
//
// Scoreboard bench for fwd_tracker with default parameters. Each cycle the
// stimulus task drives the inputs, asks a small behavioural model for the
// expected outputs and pushes them onto a queue. On the falling edge the
// expected record is popped and compared with what the DUT shows.
// ---------------------------------------------------------------------------
module tb_fwd_tracker;

  localparam int S  = 2;
  localparam int N  = 2;
  localparam int RW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_i, flush_i;
  logic              ex_valid, ex_wr, ex_load;
  logic [RW-1:0]     ex_rd;
  logic [N*RW-1:0]   ex_rs, dec_rs;
  logic [N*S-1:0]    fwd_sel;
  logic [N-1:0]      dec_fwd;
  logic              load_use_stall;
  logic [31:0]       lu_count;

  fwd_tracker #(.STAGES(S), .NUM_SRC(N), .RW(RW)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_load(ex_load),
    .ex_rs(ex_rs), .dec_rs(dec_rs), .fwd_sel(fwd_sel), .dec_fwd(dec_fwd),
    .load_use_stall(load_use_stall), .lu_count(lu_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*S-1:0] sel;
    logic [N-1:0]   dec;
    logic           lus;
    logic [31:0]    cnt;
    string          tag;
  } expect_t;

  expect_t expQ[$];

  // Reference history, kept as plain per-stage arrays.
  bit          mValid [S];
  bit          mWr    [S];
  bit          mLoad  [S];
  bit [RW-1:0] mRd    [S];
  bit [31:0]   mCount;

  int checks   = 0;
  int failures = 0;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit modelLive(input int k);
    return mValid[k] && mWr[k] && (mRd[k] != 0);
  endfunction

  // Drive one cycle, predict the outputs, compare at the falling edge and
  // then advance the model in step with the DUT clock edge.
  task automatic applyStimulus(input bit r, input bit st, input bit fl,
                               input bit v, input bit [RW-1:0] rd,
                               input bit w, input bit ld,
                               input bit [RW-1:0] rs0, input bit [RW-1:0] rs1,
                               input bit [RW-1:0] d0, input bit [RW-1:0] d1,
                               input string tag);
    expect_t e;
    expect_t got;
    bit [RW-1:0] rs [N];
    bit [RW-1:0] ds [N];
    bit hit;
    rst = r; stall_i = st; flush_i = fl; ex_valid = v; ex_rd = rd;
    ex_wr = w; ex_load = ld;
    ex_rs  = {rs1, rs0};
    dec_rs = {d1, d0};
    rs[0] = rs0; rs[1] = rs1; ds[0] = d0; ds[1] = d1;

    e.sel = '0; e.dec = '0; hit = 0; e.tag = tag;
    for (int i = 0; i < N; i++) begin
      int m;
      m = -1;
      if (rs[i] != 0) begin
        for (int k = S - 1; k >= 0; k--) begin
          if (modelLive(k) && mRd[k] == rs[i]) m = k;
        end
      end
      if (m == 0 && mLoad[0]) hit = 1;
      else if (m >= 0) e.sel[i*S + m] = 1'b1;
      e.dec[i] = modelLive(S-1) && (mRd[S-1] == ds[i]) && (ds[i] != 0);
    end
    e.lus = hit && v && !fl;
    e.cnt = mCount;
    expQ.push_back(e);

    @(negedge clk);
    if (expQ.size() == 0) begin
      checkOutput({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      got = expQ.pop_front();
      checkOutput({got.tag, ".sel"}, 32'(fwd_sel), 32'(got.sel));
      checkOutput({got.tag, ".dec"}, 32'(dec_fwd), 32'(got.dec));
      checkOutput({got.tag, ".lus"}, 32'(load_use_stall), 32'(got.lus));
      checkOutput({got.tag, ".cnt"}, lu_count, got.cnt);
    end

    if (r) begin
      for (int k = 0; k < S; k++) mValid[k] = 0;
      mCount = 0;
    end else if (!st) begin
      for (int k = S - 1; k >= 1; k--) begin
        mValid[k] = mValid[k-1]; mWr[k] = mWr[k-1];
        mLoad[k]  = mLoad[k-1];  mRd[k] = mRd[k-1];
      end
      mValid[0] = v && !fl && !e.lus;
      mWr[0] = w; mLoad[0] = ld; mRd[0] = rd;
      if (e.lus && mCount != 32'hFFFF_FFFF) mCount = mCount + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    for (int k = 0; k < S; k++) begin
      mValid[k] = 0; mWr[k] = 0; mLoad[k] = 0; mRd[k] = 0;
    end
    mCount = 0;
    rst = 1; stall_i = 0; flush_i = 0; ex_valid = 0; ex_rd = 0;
    ex_wr = 0; ex_load = 0; ex_rs = '0; dec_rs = '0;
    @(posedge clk); #1;
    applyStimulus(1, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0, "rst");
    idle("postrst");

    // Back-to-back ALU producer of x5.
    applyStimulus(0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, "alu.prod");
    applyStimulus(0, 0, 0, 1, 6, 1, 0, 5, 0, 0, 0, "alu.cons");
    idle("alu.gap");

    // Load of x7 followed by a dependent consumer on source 1.
    applyStimulus(0, 0, 0, 1, 7, 1, 1, 0, 0, 0, 0, "lu.load");
    applyStimulus(0, 0, 0, 1, 8, 1, 0, 0, 7, 0, 0, "lu.stall");
    applyStimulus(0, 0, 0, 1, 8, 1, 0, 0, 7, 0, 0, "lu.fwd");
    idle("lu.gap");

    // Two writers of x3, youngest must win.
    applyStimulus(0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, "pri.w1");
    applyStimulus(0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, "pri.w2");
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 3, 3, 0, 0, "pri.cons");

    // Store to x4 does not write; writer of x0 never forwards.
    applyStimulus(0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, "st.store");
    applyStimulus(0, 0, 0, 1, 0, 1, 0, 4, 4, 0, 0, "st.cons");
    applyStimulus(0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, "x0.cons");
    idle("x0.gap");

    // Stall for three cycles with a load-use pending, then release.
    applyStimulus(0, 0, 0, 1, 7, 1, 1, 0, 0, 0, 0, "stl.load");
    applyStimulus(0, 1, 0, 1, 9, 1, 0, 7, 0, 0, 0, "stl.1");
    applyStimulus(0, 1, 0, 1, 9, 1, 0, 7, 0, 0, 0, "stl.2");
    applyStimulus(0, 1, 0, 1, 9, 1, 0, 7, 0, 0, 0, "stl.3");
    applyStimulus(0, 0, 0, 1, 9, 1, 0, 7, 0, 0, 0, "stl.go");
    applyStimulus(0, 0, 0, 1, 9, 1, 0, 7, 0, 0, 0, "stl.fwd");
    idle("stl.gap");

    // Flushed producer of x6 must never forward.
    applyStimulus(0, 0, 1, 1, 6, 1, 0, 0, 0, 0, 0, "fl.prod");
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 6, 6, 0, 0, "fl.c1");
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 6, 6, 0, 0, "fl.c2");

    // Producer of x9 reaches write-back; decode bypass on source 0.
    applyStimulus(0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, "dec.prod");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, "dec.mem");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 0, 9, 2, "dec.wb");

    // Reset in flight discards the producer of x10.
    applyStimulus(0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0, "mr.prod");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 10, 0, 10, 0, "mr.rst");
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 10, 10, 10, 10, "mr.cons");

    // Saturation: counter pinned at all-ones across a load-use edge.
    applyStimulus(0, 0, 0, 1, 7, 1, 1, 0, 0, 0, 0, "sat.load");
    force dut.lu_count_q = 32'hFFFF_FFFF;
    mCount = 32'hFFFF_FFFF;
    applyStimulus(0, 0, 0, 1, 8, 1, 0, 7, 0, 0, 0, "sat.hit");
    release dut.lu_count_q;
    applyStimulus(0, 1, 0, 1, 8, 1, 0, 7, 0, 0, 0, "sat.stall");
    applyStimulus(0, 0, 0, 1, 11, 1, 1, 0, 0, 0, 0, "sat.load2");
    applyStimulus(0, 0, 0, 1, 12, 1, 0, 11, 0, 0, 0, "sat.hit2");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "sat.after");

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rnd.rst");
    // Random mix over a small register range to provoke collisions.
    for (int n = 0; n < 80; n++) begin
      applyStimulus(0, ($urandom_range(7) == 0), ($urandom_range(7) == 0),
                    ($urandom_range(5) != 0), RW'($urandom_range(3)),
                    1'($urandom_range(1)), 1'($urandom_range(1)),
                    RW'($urandom_range(3)), RW'($urandom_range(3)),
                    RW'($urandom_range(3)), RW'($urandom_range(3)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout got=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fwd_tracker.md
FWD_TRACKER -- requirements
Module: fwd_tracker

Interface
REQ-001 SHALL have parameter STAGES, default 2, range 1..4: number of post-execute pipeline stages tracked for forwarding.
REQ-002 SHALL have parameter NUM_SRC, default 2, range 1..4: number of source operands per instruction.
REQ-003 SHALL have parameter RW, default 5: register index width.
REQ-004 SHALL use one clock; reset is synchronous and active-high, ports named clk and rst.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 stall_i  in  1  pipeline freeze; tracker holds all state.
REQ-008 flush_i  in  1  squash the instruction currently in EX.
REQ-009 ex_valid  in  1  EX slot holds a real instruction.
REQ-010 ex_rd  in  RW  EX destination register.
REQ-011 ex_wr  in  1  EX instruction writes rd; low for store and branch.
REQ-012 ex_load  in  1  EX instruction is a load.
REQ-013 ex_rs  in  NUM_SRC*RW  EX source registers; source i in bits [i*RW +: RW].
REQ-014 dec_rs  in  NUM_SRC*RW  decode-stage source registers, same packing.
REQ-015 fwd_sel  out  NUM_SRC*STAGES  one-hot per source; bit i*STAGES+k selects the stage-k result for EX source i.
REQ-016 dec_fwd  out  NUM_SRC  decode source i reads the stage STAGES-1 (write-back) result.
REQ-017 load_use_stall  out  1  EX must hold for a load-use hazard.
REQ-018 lu_count  out  32  saturating count of load_use_stall cycles.

Function
REQ-019 SHALL keep STAGES entries {valid, rd, wr, load}; entry 0 is youngest (MEM), entry STAGES-1 is oldest (WB).
REQ-020 Entry k SHALL be "live" when valid=1, wr=1 and rd!=0.
REQ-021 On a clock edge with stall_i=0, entry k SHALL load entry k-1 for k>=1.
REQ-022 On the same edge, entry 0 SHALL load {ex_valid, ex_rd, ex_wr, ex_load}.
REQ-023 Entry 0 SHALL load a bubble (valid=0) instead when flush_i=1, load_use_stall=1 or ex_valid=0.
REQ-024 With stall_i=1, all entries and lu_count SHALL hold, and outputs SHALL still be computed combinationally from the held state.
REQ-025 For each source i, the matching stage SHALL be the lowest k whose entry is live with rd == ex_rs[i]; youngest wins.
REQ-026 fwd_sel bit for (i,k) SHALL be 1 only for that matching k, with no match giving all zeros.
REQ-027 fwd_sel for source i SHALL also be all zeros when the match is entry 0 with load=1 (data not yet available).
REQ-028 load_use_stall SHALL be 1 when any source i matches entry 0 with load=1 and ex_valid=1 and flush_i=0.
REQ-029 Loads in entries k>=1 SHALL forward normally.
REQ-030 dec_fwd[i] SHALL be 1 when entry STAGES-1 is live and rd == dec_rs[i]; this output ignores younger entries.
REQ-031 Source register x0 SHALL never match, whatever the entry contents.
REQ-032 lu_count SHALL increment by 1 on each edge where load_use_stall=1 and stall_i=0.
REQ-033 lu_count SHALL saturate at 0xFFFFFFFF, with no wrap.
REQ-034 The block SHALL be fully combinational from state and inputs to fwd_sel, dec_fwd and load_use_stall, with zero-cycle latency.
REQ-035 Forward selects SHALL track state one cycle after issue; the producer appears in entry 0 the cycle after it leaves EX.

Reset
REQ-036 When rst=1 at an edge, all entry valid bits and lu_count SHALL clear to 0, overriding stall_i and all other inputs.
REQ-037 In the cycle after reset, fwd_sel, dec_fwd and load_use_stall SHALL be 0, apart from the combinational load_use_stall, which is 0 since no entry is valid.
REQ-038 Reset mid-operation SHALL discard in-flight entries with no forwarding from them afterwards.

Verification
REQ-039 Back-to-back ALU: issue add x5 (ex_wr=1), next cycle ex_rs[0]=5 -> fwd_sel[0*STAGES+0]=1, load_use_stall=0.
REQ-040 Load-use: issue lw x7, next cycle ex_rs[1]=7 -> load_use_stall=1 for one cycle, then entry 0 is a bubble and fwd_sel[1*STAGES+1]=1, lu_count=1.
REQ-041 Priority: x3 written in two consecutive instructions, consumer reads x3 -> only stage-0 bit is set, stage-1 bit is 0.
REQ-042 x0 and non-writing stores: store with ex_rd=4, ex_wr=0, then consumer rs=4 -> fwd_sel=0; write to x0 with consumer rs=0 -> fwd_sel=0.
REQ-043 Stall/flush: stall_i=1 for 3 cycles holds fwd_sel and lu_count constant; flush_i=1 on a producer -> no later forwarding from it.
REQ-044 Decode bypass and saturation: producer of x9 at WB with dec_rs[0]=9 -> dec_fwd[0]=1; lu_count preloaded at 0xFFFFFFFF via force, plus a stall -> remains 0xFFFFFFFF.
